multicycle_core: RTL
====================

# multicycle_core

Parametrised multi-cycle processor core that replaces the free-running, event-sequenced CPU loop with a clocked state machine. It runs the team's 8-bit instruction format over a 4-entry register file of configurable data width. Instruction and data memories are external, reached through req/ack handshakes that tolerate any number of wait cycles. It sits between the instruction memory and data memory blocks and adds halt and retire status that the previous core lacked.

## Interface
- DATA_W, 8, register/ALU/data-memory word width (≥2)
- PC_W, 8, program counter and instruction address width
- ADDR_W, 8, data-memory address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- i_req  out  1  instruction fetch request, high throughout FETCH
- i_addr  out  PC_W  fetch address (= pc)
- i_ack  in  1  fetch complete; i_data valid this cycle
- i_data  in  8  instruction word
- d_req  out  1  data access request, high throughout MEM
- d_we  out  1  1 = store, 0 = load; valid while d_req
- d_addr  out  ADDR_W  data address
- d_wdata  out  DATA_W  store data
- d_ack  in  1  data access complete; d_rdata valid this cycle for loads
- d_rdata  in  DATA_W  load data
- pc  out  PC_W  current program counter
- state  out  3  FSM state encoding, for debug
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  high while in HALT

## Operation
- Format: opcode = instr[7:4], ra = instr[3:2], rb = instr[1:0]. Register file r0..r3, DATA_W each.
- Opcodes: 0000 add ra←ra+rb; 0001 sub ra←ra−rb; 0010 and; 0011 or; 0100 slt ra←(ra<rb unsigned)?1:0; 0101 li ra←zero-extend(rb field); 1010 lw ra←mem[rb]; 1011 sw mem[rb]←ra; 1100 beq; 1101 bne; 1110 jr pc←ra; 1111 halt; all others nop (pc+1, no write).
- Branch: beq taken when ra==rb, bne when ra≠rb; taken pc←pc+r0 (r0 taken as signed, sign-extended or truncated to PC_W); not taken pc←pc+1. r0 is an ordinary writable register.
- Arithmetic wraps modulo 2^DATA_W; pc wraps modulo 2^PC_W (pc=all-ones +1 → 0). jr truncates/zero-extends ra to PC_W. d_addr = rb value truncated/zero-extended to ADDR_W.
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5).
- FETCH: i_req=1, i_addr=pc; on i_ack latch i_data into instruction register → DECODE; else stay.
- DECODE: read ra/rb operands into operand registers; opcode 1111 → HALT; else → EXEC.
- EXEC: compute ALU result, branch target, memory address/data; lw/sw → MEM; all others → WB.
- MEM: d_req=1, d_we=(sw), d_addr/d_wdata held stable; on d_ack latch d_rdata (lw) → WB; else stay.
- WB: write ra for ALU ops, li and lw; update pc (branch/jr target or pc+1); retire=1; → FETCH.
- HALT: halted=1, no requests, pc frozen; leave only by reset.
- Reset values: state=FETCH, pc=RESET_PC, r0..r3=0, instruction register=0, retire=0, halted=0. i_req is 1 from the first post-reset cycle; d_req=0, d_we=0, d_addr=0, d_wdata=0.

## Timing
- i_req, d_req, d_we, d_addr, d_wdata, i_addr decode from registered state/operands; no combinational path from ack to req.
- Ack sampled on the rising edge while req is high; ack while req low is ignored.
- Zero-wait latency: ALU/branch/jr/nop 4 cycles (FETCH, DECODE, EXEC, WB); lw/sw 5 cycles. Each wait cycle on i_ack/d_ack adds one cycle.
- Register writes land at the WB edge, so the next instruction's DECODE sees them (no hazards, no forwarding needed).
- Reset asserted mid-handshake: at that edge the core returns to FETCH with reset values; any ack in the reset cycle is discarded; d_req drops after the edge.
- Reset has priority over every transition, including HALT.

## Test plan
- Reset then zero-wait fetch of li r1,3 (0x57): i_addr=0; r1=3, retire pulse in cycle 4, pc=1.
- add wrap (DATA_W=8), r1=0xFF, r2=0x02, add r1,r2 (0x06) → r1=0x01; sub r2,r1 with r2=0x00, r1=0x01 → r2=0xFF.
- sw r1,[r2] then lw r3,[r2] with d_ack delayed 3 cycles: d_req held with stable d_addr/d_wdata, d_we=1 then 0, r3=r1, lw takes 8 cycles.
- beq with r0=0xFE at pc=5, operands equal → pc=3; bne same operands → pc=6; jr from pc=0xFF with pc+1 path wraps to 0.
- halt (0xF0): halted=1 from cycle 3 on, i_req stays 0 for 20 cycles, pc unchanged; reset → FETCH, pc=RESET_PC.
- Reset pulsed while MEM waits on d_ack with d_ack arriving in the reset cycle: no register write, state=FETCH, d_req=0 next cycle.

Source files
------------

// File: rtl/multicycle_core_if.sv
// -----------------------------------------------------------------------------
// multicycle_core_if
// Bus bundle between the multicycle core and its external instruction and data
// memories. Both memories use a req/ack handshake; the core holds the request
// and its address/data stable until the memory returns ack.
//   master (core side):  drives i_req, i_addr, d_req, d_we, d_addr, d_wdata
//                        samples i_ack, i_data, d_ack, d_rdata
//   slave  (memory side): the mirror image of master
// -----------------------------------------------------------------------------
interface multicycle_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int ADDR_W = 8
);
  logic              i_req;
  logic [PC_W-1:0]   i_addr;
  logic              i_ack;
  logic [7:0]        i_data;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ack, i_data, d_ack, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ack, i_data, d_ack, d_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
// Multi-cycle processor for the 8-bit instruction format
// (opcode = instr[7:4], ra = instr[3:2], rb = instr[1:0]) over a 4-entry
// register file. Each instruction walks FETCH -> DECODE -> EXEC -> [MEM] -> WB;
// opcode 1111 parks the core in HALT until reset.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset (wins over every transition)
//   bus     master side of the instruction/data memory handshakes
//   pc      current program counter
//   state   FSM state (0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT)
//   retire  one-cycle pulse in WB of every completed instruction
//   halted  high while in HALT
// All bus outputs and status outputs are registers, so there is no
// combinational path from an ack back to a request.
// -----------------------------------------------------------------------------
module multicycle_core #(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 8,
  parameter int              ADDR_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_core_if.master bus,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BNE  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Width adapters: register values reused as pc / data address / branch offset.
  function automatic logic [PC_W-1:0] zext_pc(input logic [DATA_W-1:0] v);
    return PC_W'(v);
  endfunction

  function automatic logic [PC_W-1:0] sext_pc(input logic [DATA_W-1:0] v);
    return PC_W'($signed(v));
  endfunction

  function automatic logic [ADDR_W-1:0] zext_addr(input logic [DATA_W-1:0] v);
    return ADDR_W'(v);
  endfunction

  state_t            state_r;
  logic [PC_W-1:0]   pc_r;
  logic [PC_W-1:0]   npc_r;
  logic [7:0]        ir_r;
  logic [DATA_W-1:0] rf_r [4];
  logic [DATA_W-1:0] opa_r;
  logic [DATA_W-1:0] opb_r;
  logic [DATA_W-1:0] res_r;
  logic              wen_r;
  logic              i_req_r;
  logic              d_req_r;
  logic              d_we_r;
  logic [ADDR_W-1:0] d_addr_r;
  logic [DATA_W-1:0] d_wdata_r;
  logic              retire_r;
  logic              halted_r;

  logic [3:0]        opcode_s;
  logic [1:0]        ra_s;
  logic [1:0]        rb_s;
  logic [DATA_W-1:0] alu_s;
  logic [PC_W-1:0]   npc_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic              wr_s;
  logic              mem_s;

  assign opcode_s = ir_r[7:4];
  assign ra_s     = ir_r[3:2];
  assign rb_s     = ir_r[1:0];
  assign pc_inc_s = pc_r + PC_W'(1'b1);

  assign bus.i_req   = i_req_r;
  assign bus.i_addr  = pc_r;
  assign bus.d_req   = d_req_r;
  assign bus.d_we    = d_we_r;
  assign bus.d_addr  = d_addr_r;
  assign bus.d_wdata = d_wdata_r;
  assign pc          = pc_r;
  assign state       = state_r;
  assign retire      = retire_r;
  assign halted      = halted_r;

  // EXEC-stage datapath: ALU result, write-back enable, memory flag and next pc.
  // r0 is read live here; nothing writes the register file between DECODE and WB.
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    wr_s  = 1'b0;
    mem_s = 1'b0;
    npc_s = pc_inc_s;
    case (opcode_s)
      OP_ADD: begin alu_s = opa_r + opb_r; wr_s = 1'b1; end
      OP_SUB: begin alu_s = opa_r - opb_r; wr_s = 1'b1; end
      OP_AND: begin alu_s = opa_r & opb_r; wr_s = 1'b1; end
      OP_OR:  begin alu_s = opa_r | opb_r; wr_s = 1'b1; end
      OP_SLT: begin alu_s = DATA_W'(opa_r < opb_r); wr_s = 1'b1; end
      OP_LI:  begin alu_s = DATA_W'(rb_s); wr_s = 1'b1; end
      OP_LW:  begin mem_s = 1'b1; wr_s = 1'b1; end
      OP_SW:  begin mem_s = 1'b1; end
      OP_BEQ: begin
        if (opa_r == opb_r) begin
          npc_s = pc_r + sext_pc(rf_r[0]);
        end else begin
          npc_s = pc_inc_s;
        end
      end
      OP_BNE: begin
        if (opa_r != opb_r) begin
          npc_s = pc_r + sext_pc(rf_r[0]);
        end else begin
          npc_s = pc_inc_s;
        end
      end
      OP_JR:  begin npc_s = zext_pc(opa_r); end
      default: begin npc_s = pc_inc_s; end
    endcase
  end

  // Control FSM with registered bus/status outputs and architectural state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      pc_r      <= RESET_PC;
      npc_r     <= RESET_PC;
      ir_r      <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
      opa_r     <= {DATA_W{1'b0}};
      opb_r     <= {DATA_W{1'b0}};
      res_r     <= {DATA_W{1'b0}};
      wen_r     <= 1'b0;
      i_req_r   <= 1'b1;
      d_req_r   <= 1'b0;
      d_we_r    <= 1'b0;
      d_addr_r  <= {ADDR_W{1'b0}};
      d_wdata_r <= {DATA_W{1'b0}};
      retire_r  <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          if (bus.i_ack) begin
            ir_r    <= bus.i_data;
            i_req_r <= 1'b0;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          opa_r <= rf_r[ra_s];
          opb_r <= rf_r[rb_s];
          if (opcode_s == OP_HALT) begin
            halted_r <= 1'b1;
            state_r  <= S_HALT;
          end else begin
            state_r  <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_r <= alu_s;
          wen_r <= wr_s;
          npc_r <= npc_s;
          if (mem_s) begin
            d_req_r   <= 1'b1;
            d_we_r    <= (opcode_s == OP_SW);
            d_addr_r  <= zext_addr(opb_r);
            d_wdata_r <= opa_r;
            state_r   <= S_MEM;
          end else begin
            retire_r  <= 1'b1;
            state_r   <= S_WB;
          end
        end
        S_MEM: begin
          if (bus.d_ack) begin
            if (!d_we_r) begin
              res_r <= bus.d_rdata;
            end
            d_req_r  <= 1'b0;
            d_we_r   <= 1'b0;
            retire_r <= 1'b1;
            state_r  <= S_WB;
          end
        end
        S_WB: begin
          if (wen_r) begin
            rf_r[ra_s] <= res_r;
          end
          pc_r     <= npc_r;
          retire_r <= 1'b0;
          i_req_r  <= 1'b1;
          state_r  <= S_FETCH;
        end
        S_HALT: begin
          halted_r <= 1'b1;
          i_req_r  <= 1'b0;
          d_req_r  <= 1'b0;
        end
        default: begin
          state_r  <= S_FETCH;
          i_req_r  <= 1'b1;
          d_req_r  <= 1'b0;
          retire_r <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
